// File: rtl/mult16_rr_sched_if.sv
// Request/response bundle for the two-client 16x16 multiply scheduler.
// The slave side is the scheduler; the master side is the requesters plus the result consumer.
interface mult16_rr_sched_if;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_x;
  logic [15:0] a_y;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_x;
  logic [15:0] b_y;
  logic        out_valid;
  logic        out_ready;
  logic        out_id;
  logic [31:0] out_prod;
  logic        busy;
  logic [7:0]  ops_done;

  modport slave (
    input  a_valid, a_x, a_y, b_valid, b_x, b_y, out_ready,
    output a_ready, b_ready, out_valid, out_id, out_prod, busy, ops_done
  );

  modport master (
    output a_valid, a_x, a_y, b_valid, b_x, b_y, out_ready,
    input  a_ready, b_ready, out_valid, out_id, out_prod, busy, ops_done
  );
endinterface

// File: rtl/mult16_rr_sched.sv
// Round-robin scheduler for two requesters sharing one sequential 16x16 shift-add multiplier.
// One operation runs for exactly 16 iterations, then the result is held until the consumer takes it.
module mult16_rr_sched (
  input  logic                   clk,
  input  logic                   rst,
  mult16_rr_sched_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // 0 = A, 1 = B
  logic        id_q, id_d;
  logic [15:0] m_q, m_d;
  logic [32:0] p_q, p_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  ops_q, ops_d;

  logic        sel_b;
  logic        a_rdy;
  logic        b_rdy;
  logic        accept;
  logic [15:0] sel_x;
  logic [15:0] sel_y;

  // One shift-add step: conditionally add M to the upper half, then shift the whole register right.
  function automatic logic [32:0] shift_add_step(input logic [32:0] p, input logic [15:0] m);
    logic [16:0] s;
    s = p[0] ? ({1'b0, p[31:16]} + {1'b0, m}) : {1'b0, p[31:16]};
    return {s, p[15:0]} >> 1;
  endfunction

  always_comb begin
    sel_b = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      sel_b = ~last_q;
    end else if (bus.b_valid) begin
      sel_b = 1'b1;
    end
    a_rdy  = (state_q == IDLE) && bus.a_valid && !sel_b;
    b_rdy  = (state_q == IDLE) && bus.b_valid && sel_b;
    accept = a_rdy || b_rdy;
    sel_x  = sel_b ? bus.b_x : bus.a_x;
    sel_y  = sel_b ? bus.b_y : bus.a_y;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          m_d     = sel_x;
          p_d     = {17'b0, sel_y};
          cnt_d   = 4'd0;
          id_d    = sel_b;
          last_d  = sel_b;
          state_d = BUSY;
        end
      end
      BUSY: begin
        p_d   = shift_add_step(p_q, m_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // No accept on the handshake edge; arbitration resumes from IDLE next cycle.
        if (bus.out_ready) begin
          ops_d   = ops_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      m_q     <= 16'd0;
      p_q     <= 33'd0;
      cnt_q   <= 4'd0;
      ops_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_id    = id_q;
  assign bus.out_prod  = p_q[31:0];
  assign bus.busy      = (state_q != IDLE);
  assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_mult16_rr_sched.sv
// Scoreboard bench for mult16_rr_sched: drivers issue requests, a negedge monitor predicts
// arbitration, products, latency and the completion count from plain arithmetic.
module tb_mult16_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;

  mult16_rr_sched_if bus ();

  mult16_rr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic        id;
    logic [31:0] prod;
    int          acc;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         stim_to = 0;
  bit         stim_done = 1'b0;
  bit         last_m = 1'b1;
  logic [7:0] model_ops = 8'd0;
  bit         front_seen = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor and scoreboard.
  always @(negedge clk) begin
    bit   free;
    exp_t e;
    if (rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ops_done", 64'(bus.ops_done), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_out_prod", 64'(bus.out_prod), 64'd0);
      chk("rst_out_id", 64'(bus.out_id), 64'd0);
      exp_q.delete();
      last_m     = 1'b1;
      model_ops  = 8'd0;
      front_seen = 1'b0;
    end else begin
      chk("ops_done", 64'(bus.ops_done), 64'(model_ops));
      free = (exp_q.size() == 0);
      chk("busy", 64'(bus.busy), 64'(!free));
      chk("a_ready", 64'(bus.a_ready), 64'(free && bus.a_valid && (!bus.b_valid || last_m)));
      chk("b_ready", 64'(bus.b_ready), 64'(free && bus.b_valid && (!bus.a_valid || !last_m)));
      if (bus.out_valid) begin
        if (free) begin
          chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          if (!front_seen) begin
            chk("latency", 64'(cycle - e.acc), 64'd17);
            front_seen = 1'b1;
          end
          chk("out_id", 64'(bus.out_id), 64'(e.id));
          chk("out_prod", 64'(bus.out_prod), 64'(e.prod));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            model_ops  = model_ops + 8'd1;
            front_seen = 1'b0;
          end
        end
      end
      if (bus.a_valid && bus.a_ready) begin
        exp_q.push_back('{id: 1'b0, prod: 32'(bus.a_x) * 32'(bus.a_y), acc: cycle});
        last_m = 1'b0;
      end else if (bus.b_valid && bus.b_ready) begin
        exp_q.push_back('{id: 1'b1, prod: 32'(bus.b_x) * 32'(bus.b_y), acc: cycle});
        last_m = 1'b1;
      end
    end
    if (stim_done || cycle > 60000) begin
      chk("stim_timeouts", 64'(stim_to), 64'd0);
      chk("finished_in_time", 64'(stim_done), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  // Present one request and wait (bounded) for its accept; optionally keep valid asserted afterwards.
  task automatic do_req(input bit is_b, input logic [15:0] x, input logic [15:0] y, input bit hold);
    bit got = 1'b0;
    if (is_b) begin
      bus.b_x = x; bus.b_y = y; bus.b_valid = 1'b1;
    end else begin
      bus.a_x = x; bus.a_y = y; bus.a_valid = 1'b1;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (is_b ? bus.b_ready : bus.a_ready) got = 1'b1;
    end
    if (!got) stim_to++;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (is_b) bus.b_valid = 1'b0;
      else      bus.a_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) stim_to++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.a_x       = 16'd0;
    bus.a_y       = 16'd0;
    bus.b_x       = 16'd0;
    bus.b_y       = 16'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Largest operands from A alone.
    do_req(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    drain();

    // Both requesters held valid: expect A, B, A, B.
    fork
      begin
        do_req(1'b0, 16'd3, 16'd5, 1'b1);
        do_req(1'b0, 16'd3, 16'd5, 1'b0);
      end
      begin
        do_req(1'b1, 16'h1234, 16'h0100, 1'b1);
        do_req(1'b1, 16'h1234, 16'h0100, 1'b0);
      end
    join
    drain();

    // Backpressure with a competing B request waiting.
    bus.out_ready = 1'b0;
    do_req(1'b0, 16'h8000, 16'h0002, 1'b0);
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    if (!bus.out_valid) stim_to++;
    fork
      do_req(1'b1, 16'h0007, 16'h0009, 1'b0);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Zero operands still take the full iteration count.
    do_req(1'b0, 16'h0000, 16'hABCD, 1'b0);
    drain();
    do_req(1'b1, 16'hABCD, 16'h0000, 1'b0);
    drain();

    // Reset in the middle of a B operation, then a tie that A must win.
    do_req(1'b1, 16'h1357, 16'h2468, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fork
      do_req(1'b0, 16'h0011, 16'h0022, 1'b0);
      do_req(1'b1, 16'h0033, 16'h0044, 1'b0);
    join
    drain();

    // 256 back-to-back random A operations from a clean count.
    pulse_rst();
    for (int n = 0; n < 256; n++) begin
      do_req(1'b0, 16'($urandom), 16'($urandom), (n != 255));
    end
    drain();

    stim_done = 1'b1;
  end

endmodule

// File: doc/mult16_rr_sched.md
# mult16_rr_sched

Two-requester scheduler and sequencer for a shared 16x16 unsigned multiply resource. It arbitrates round-robin between requester ports A and B, then runs one shared shift-add datapath for 16 iterations. It returns the exact 32-bit product with the requester ID over a valid/ready response port. It sits between the accelerator front-ends and the multiplier partition slices, so one multiply datapath serves two clients.

## Interface
- No parameters; operand width fixed at 16, product width fixed at 32.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  A's operation accepted this edge when a_valid high.
- a_x, a_y  in  16 each  A's operands (unsigned).
- b_valid / b_ready / b_x / b_y  same as A, for requester B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_id  out  1  0 = A, 1 = B.
- out_prod  out  32  x*y, unsigned, exact.
- busy  out  1  high in BUSY or DONE.
- ops_done  out  8  count of completed result handshakes, wraps 255->0.

## Operation
- States: IDLE, BUSY, DONE.
- **Arbitration (IDLE only)**
  - If exactly one requester is valid, select it.
  - If both are valid, select the requester other than `last`.
  - `last` resets to B, so A wins the first tie.
  - Ready is combinational: only the selected requester's `*_ready` is high. Both readies are low outside IDLE and when neither requester is valid.
- **Accept edge** (selected valid & ready)
  - Latch operand x as multiplicand M.
  - Load P[32:0] = {17'b0, y}.
  - Set cnt = 0, set id to the selected requester, update `last` to the selected requester.
  - Go to BUSY.
- **BUSY iteration** (one per edge)
  - s[16:0] = P[0] ? P[31:16] + M : {1'b0, P[31:16]}.
  - P <= {s, P[15:0]} >> 1.
  - cnt <= cnt + 1.
  - On the edge where cnt == 15, go to DONE.
  - Exactly 16 iterations, no early exit; zero operands also take 16 iterations.
- **DONE**
  - out_valid high; out_prod = P[31:0]; out_id = id.
  - All outputs stay stable until out_ready.
  - On the out_valid & out_ready edge: go to IDLE and increment ops_done.
  - There is no new accept in the same edge as the result handshake; the next accept is possible one cycle later.
- Requests that are not accepted wait with no timeout. Operand changes while valid is high and ready is low are ignored.

## Timing
- **Reset values:** state IDLE, a_ready = b_ready = 0 unless the requester is valid in IDLE, out_valid = 0, out_id = 0, out_prod = 0, busy = 0, ops_done = 0, last = B, P = 0, cnt = 0.
- **Latency:** out_valid rises in the 16th cycle after the accept edge (accept at edge E0, iterations at E1..E16, out_valid high after E16).
- **Throughput:** with out_ready tied high, one result every 18 cycles per accepted operation (1 accept cycle + 16 BUSY + 1 DONE), then IDLE.
- **Backpressure:** with out_ready low, the block holds DONE indefinitely; a_ready and b_ready stay 0.
- **Reset mid-operation** (BUSY or DONE): immediate return to IDLE with all reset values; the in-flight result is discarded; ops_done clears.
- **Simultaneous events:** both valid in IDLE → only one ready; `last` updates only on an actual accept, never on idle cycles.
- **ops_done** increments on the result handshake edge only; 255 + 1 = 0.

## Test plan
- A only, a_x = 0xFFFF, a_y = 0xFFFF → a_ready high for 1 cycle; out_valid 16 cycles after accept with out_prod = 0xFFFE0001, out_id = 0; ops_done = 1.
- A and B held valid continuously after reset (A: 3*5, B: 0x1234*0x0100) with out_ready = 1 → results in order id 0 (15), id 1 (0x00123400), id 0, id 1; no starvation.
- out_ready low for 5 cycles after out_valid (operands 0x8000*2) → out_prod = 0x00010000 stable throughout; no ready asserted; IDLE one cycle after the handshake.
- Zero operands: 0x0000*0xABCD and 0xABCD*0x0000 → out_prod = 0, still 16-cycle latency.
- rst pulsed at iteration 7 of a B operation → out_valid = 0 and ops_done = 0 immediately; the next tie goes to A.
- 256 back-to-back A operations (random operands checked against a reference model) → every product exact; ops_done wraps to 0.
